// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multi-cycle ALU control unit: ALU codes, funct/ALUOp values, MDU ops, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_ctrl_pkg;

  // ALU operation codes driven towards the ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // R-type funct field values
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;

  // ALUOp classes from the main decoder (110/111 reserved)
  localparam logic [2:0] AOP_ADD = 3'b000;
  localparam logic [2:0] AOP_SUB = 3'b001;
  localparam logic [2:0] AOP_R   = 3'b010;
  localparam logic [2:0] AOP_SLT = 3'b011;
  localparam logic [2:0] AOP_AND = 3'b100;
  localparam logic [2:0] AOP_OR  = 3'b101;

  // MDU operations; bit 1 distinguishes divide from multiply
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  // HI/LO read select
  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_HI   = 2'b01;
  localparam logic [1:0] HILO_LO   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_funct_decoder.sv
// Pure decode of ALUOp/funct into ALU code, MDU request, HI/LO select and illegal indication.
// Latency: 0 cycles (combinational).
// Backpressure: none; the caller gates the outputs with valid and FSM state.
module alu_funct_decoder
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4
) (
  input  logic [ALUOP_W-1:0] i_aluop,
  input  logic [5:0]         i_funct,
  output logic [CTRL_W-1:0]  o_alu_ctrl,
  output logic               o_is_mdu,
  output logic [1:0]         o_mdu_op,
  output logic [1:0]         o_hilo_sel,
  output logic               o_illegal
);

  logic [3:0] w_code;

  // Table decode; anything not listed falls to NOP and is flagged illegal
  always_comb begin
    w_code     = ALU_NOP;
    o_is_mdu   = 1'b0;
    o_mdu_op   = MDU_MULT;
    o_hilo_sel = HILO_NONE;
    o_illegal  = 1'b0;
    case (i_aluop)
      ALUOP_W'(AOP_ADD): w_code = ALU_ADD;
      ALUOP_W'(AOP_SUB): w_code = ALU_SUB;
      ALUOP_W'(AOP_SLT): w_code = ALU_SLT;
      ALUOP_W'(AOP_AND): w_code = ALU_AND;
      ALUOP_W'(AOP_OR):  w_code = ALU_OR;
      ALUOP_W'(AOP_R): begin
        case (i_funct)
          F_ADD:  w_code = ALU_ADD;
          F_SUB:  w_code = ALU_SUB;
          F_AND:  w_code = ALU_AND;
          F_OR:   w_code = ALU_OR;
          F_NOR:  w_code = ALU_NOR;
          F_SLT:  w_code = ALU_SLT;
          F_SLL:  w_code = ALU_SLL;
          F_SRL:  w_code = ALU_SRL;
          F_MFHI: o_hilo_sel = HILO_HI;
          F_MFLO: o_hilo_sel = HILO_LO;
          // The ALU idles while the MDU works, so mult/div keep the NOP code
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            o_is_mdu = 1'b1;
            o_mdu_op = i_funct[1:0];
          end
          default: o_illegal = 1'b1;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_alu_ctrl = CTRL_W'(w_code);

endmodule

// File: rtl/alu_ctrl_mc.sv
// EX-stage ALU control: zero-latency ALU decode plus IDLE/BUSY/DONE sequencing of the iterative MDU.
// Latency: ALU code same cycle; HI/LO write N+1 cycles after an MDU op is accepted.
// Backpressure: stall_o holds upstream for the accept cycle and all N busy cycles.
// Optional feature: ALU_CTRL_ILLEGAL_TRAP_EN enables the sticky illegal_o flag.
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 3,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [5:0]         funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               mdu_start_o,
  output logic [1:0]         mdu_op_o,
  output logic               stall_o,
  output logic               hilo_we_o,
  output logic [1:0]         hilo_sel_o,
  output logic               illegal_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  state_t             r_state, w_next_state;
  logic [CNT_W-1:0]   r_cnt, w_next_cnt;
  logic [1:0]         r_op, w_next_op;

  logic [CTRL_W-1:0]  w_dec_ctrl;
  logic               w_dec_is_mdu;
  logic [1:0]         w_dec_op;
  logic [1:0]         w_dec_sel;
  logic               w_dec_illegal;
  logic               w_decode_en;
  logic               w_accept;

  alu_funct_decoder #(
    .ALUOP_W (ALUOP_W),
    .CTRL_W  (CTRL_W)
  ) u_dec (
    .i_aluop    (ALUOp_i),
    .i_funct    (funct_i),
    .o_alu_ctrl (w_dec_ctrl),
    .o_is_mdu   (w_dec_is_mdu),
    .o_mdu_op   (w_dec_op),
    .o_hilo_sel (w_dec_sel),
    .o_illegal  (w_dec_illegal)
  );

  // Instructions are only looked at outside BUSY; DONE decodes like IDLE
  assign w_decode_en = valid_i && (r_state != ST_BUSY);
  assign w_accept    = w_decode_en && w_dec_is_mdu;

  // Next-state, counter and output logic
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_op    = r_op;
    ALUCtrl_o    = w_decode_en ? w_dec_ctrl : CTRL_W'(ALU_NOP);
    hilo_sel_o   = w_decode_en ? w_dec_sel : HILO_NONE;
    mdu_start_o  = w_accept;
    // The MDU samples the op with the start pulse, so show the new op that cycle
    mdu_op_o     = w_accept ? w_dec_op : r_op;
    stall_o      = w_accept || (r_state == ST_BUSY);
    hilo_we_o    = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_next_state = ST_BUSY;
          w_next_op    = w_dec_op;
          w_next_cnt   = w_dec_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BUSY: begin
        w_next_cnt = r_cnt - 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register; reset drops any in-flight MDU result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= MDU_MULT;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_op    <= w_next_op;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;

  // Sticky flag: set by any decoded illegal/reserved op, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_illegal <= 1'b0;
    end else if (w_decode_en && w_dec_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal_o = r_illegal;
`else
  // Trap disabled: illegal ops just decode to NOP and the flag is discarded
  assign illegal_o = w_dec_illegal & 1'b0;
`endif

endmodule
